// File: rtl/idu_pipe_if.sv
// Decode-stage bundle: IF handshake, RegFile read ports, EX/MEM feedback, redirect and ID/EX outputs.
interface idu_pipe_if #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int OP_W    = 5
);
   logic               if_valid;
   logic               if_ready;
   logic [DATA_W-1:0]  if_pc;
   logic [31:0]        if_inst;
   logic [RADDR_W-1:0] rega_addr;
   logic [RADDR_W-1:0] regb_addr;
   logic [DATA_W-1:0]  rega_data_i;
   logic [DATA_W-1:0]  regb_data_i;
   logic [DATA_W-1:0]  ex_result;
   logic               mem_wr;
   logic [RADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0]  mem_result;
   logic               j_ce;
   logic [DATA_W-1:0]  j_addr;
   logic               ex_valid;
   logic               ex_ready_i;
   logic [OP_W-1:0]    ex_op;
   logic [DATA_W-1:0]  ex_rega;
   logic [DATA_W-1:0]  ex_regb;
   logic [DATA_W-1:0]  ex_store;
   logic               ex_wr;
   logic [RADDR_W-1:0] ex_waddr;
   logic               ex_load;
   logic               ex_storeen;

   modport master (
      output if_valid, if_pc, if_inst, rega_data_i, regb_data_i, ex_result,
             mem_wr, mem_waddr, mem_result, ex_ready_i,
      input  if_ready, rega_addr, regb_addr, j_ce, j_addr, ex_valid, ex_op,
             ex_rega, ex_regb, ex_store, ex_wr, ex_waddr, ex_load, ex_storeen
   );

   modport slave (
      input  if_valid, if_pc, if_inst, rega_data_i, regb_data_i, ex_result,
             mem_wr, mem_waddr, mem_result, ex_ready_i,
      output if_ready, rega_addr, regb_addr, j_ce, j_addr, ex_valid, ex_op,
             ex_rega, ex_regb, ex_store, ex_wr, ex_waddr, ex_load, ex_storeen
   );
endinterface

// File: rtl/idu_pipe.sv
// MIPS decode stage: one instruction per cycle, branches resolved in ID, registered ID/EX output.
// Define IDU_FWD_EN for EX/MEM forwarding; without it every RAW hazard stalls until the writer retires.
module idu_pipe #(
   parameter int DATA_W  = 32,
   parameter int RADDR_W = 5,
   parameter int OP_W    = 5
) (
   input  logic       clk,
   input  logic       rst,
   idu_pipe_if.slave  bus
);
   localparam logic [5:0] OPC_R = 6'h00, OPC_J = 6'h02, OPC_JAL = 6'h03, OPC_BEQ = 6'h04,
                          OPC_BNE = 6'h05, OPC_ADDI = 6'h08, OPC_ANDI = 6'h0C, OPC_ORI = 6'h0D,
                          OPC_XORI = 6'h0E, OPC_LUI = 6'h0F, OPC_LW = 6'h23, OPC_SW = 6'h2B;
   localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_ADD = 6'h20,
                          FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_XOR = 6'h26,
                          FN_SLT = 6'h2A;

   logic [5:0]         opcode, funct;
   logic [RADDR_W-1:0] rs, rt, rd;
   logic [4:0]         shamt;
   logic [15:0]        imm;
   logic [DATA_W-1:0]  sext_imm, zext_imm, a_val, b_val;
   logic               is_shift, use_rs, use_rt, ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
   logic               stall, rdy, fire, taken;

   logic [OP_W-1:0]    d_op;
   logic [DATA_W-1:0]  d_a, d_b, d_store;
   logic [RADDR_W-1:0] d_dst;
   logic               d_wr, d_load, d_sten;

   logic               ex_valid_q, ex_wr_q, ex_load_q, ex_sten_q;
   logic [OP_W-1:0]    ex_op_q;
   logic [DATA_W-1:0]  ex_a_q, ex_b_q, ex_store_q;
   logic [RADDR_W-1:0] ex_waddr_q;

   assign opcode   = bus.if_inst[31:26];
   assign rs       = bus.if_inst[25:21];
   assign rt       = bus.if_inst[20:16];
   assign rd       = bus.if_inst[15:11];
   assign shamt    = bus.if_inst[10:6];
   assign funct    = bus.if_inst[5:0];
   assign imm      = bus.if_inst[15:0];
   assign sext_imm = {{(DATA_W-16){imm[15]}}, imm};
   assign zext_imm = {{(DATA_W-16){1'b0}}, imm};

   assign is_shift = (opcode == OPC_R) && (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA);
   assign use_rs   = !(opcode == OPC_J || opcode == OPC_JAL || opcode == OPC_LUI || is_shift);
   assign use_rt   = (opcode == OPC_R || opcode == OPC_BEQ || opcode == OPC_BNE || opcode == OPC_SW);

   // r0 never carries a hazard: it is hard-wired and writers to it are squashed.
   assign ex_hit_a  = ex_valid_q && ex_wr_q && use_rs && rs != '0 && ex_waddr_q == rs;
   assign ex_hit_b  = ex_valid_q && ex_wr_q && use_rt && rt != '0 && ex_waddr_q == rt;
   assign mem_hit_a = bus.mem_wr && use_rs && rs != '0 && bus.mem_waddr == rs;
   assign mem_hit_b = bus.mem_wr && use_rt && rt != '0 && bus.mem_waddr == rt;

`ifdef IDU_FWD_EN
   assign stall = (ex_hit_a || ex_hit_b) && ex_load_q;
   assign a_val = ex_hit_a ? bus.ex_result : (mem_hit_a ? bus.mem_result : bus.rega_data_i);
   assign b_val = ex_hit_b ? bus.ex_result : (mem_hit_b ? bus.mem_result : bus.regb_data_i);
`else
   wire unused_fwd = ^{bus.ex_result, bus.mem_result};
   assign stall = ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b;
   assign a_val = bus.rega_data_i;
   assign b_val = bus.regb_data_i;
`endif

   assign rdy  = rst && !stall && (!ex_valid_q || bus.ex_ready_i);
   assign fire = bus.if_valid && rdy;

   always_comb begin
      d_op = '0; d_a = '0; d_b = '0; d_store = '0; d_dst = '0;
      d_wr = 1'b0; d_load = 1'b0; d_sten = 1'b0;
      case (opcode)
         OPC_R: begin
            d_a = a_val; d_b = b_val; d_dst = rd; d_wr = 1'b1;
            case (funct)
               FN_ADD: d_op = OP_W'(0);
               FN_SUB: d_op = OP_W'(1);
               FN_AND: d_op = OP_W'(2);
               FN_OR:  d_op = OP_W'(3);
               FN_XOR: d_op = OP_W'(4);
               FN_SLL: begin d_op = OP_W'(5); d_a = {{(DATA_W-5){1'b0}}, shamt}; end
               FN_SRL: begin d_op = OP_W'(6); d_a = {{(DATA_W-5){1'b0}}, shamt}; end
               FN_SRA: begin d_op = OP_W'(7); d_a = {{(DATA_W-5){1'b0}}, shamt}; end
               FN_SLT: d_op = OP_W'(8);
               default: d_wr = 1'b0;
            endcase
         end
         OPC_ADDI: begin d_a = a_val; d_b = sext_imm; d_dst = rt; d_wr = 1'b1; end
         OPC_ANDI: begin d_op = OP_W'(2); d_a = a_val; d_b = zext_imm; d_dst = rt; d_wr = 1'b1; end
         OPC_ORI:  begin d_op = OP_W'(3); d_a = a_val; d_b = zext_imm; d_dst = rt; d_wr = 1'b1; end
         OPC_XORI: begin d_op = OP_W'(4); d_a = a_val; d_b = zext_imm; d_dst = rt; d_wr = 1'b1; end
         OPC_LUI:  begin d_op = OP_W'(9); d_b = {zext_imm[DATA_W-17:0], 16'h0}; d_dst = rt; d_wr = 1'b1; end
         OPC_LW:   begin d_a = a_val; d_b = sext_imm; d_dst = rt; d_wr = 1'b1; d_load = 1'b1; end
         OPC_SW:   begin d_a = a_val; d_b = sext_imm; d_store = b_val; d_sten = 1'b1; end
         OPC_JAL:  begin d_a = bus.if_pc; d_b = DATA_W'(4); d_dst = RADDR_W'(31); d_wr = 1'b1; end
         OPC_BEQ, OPC_BNE: begin d_a = a_val; d_b = b_val; end
         default: ;
      endcase
      if (d_dst == '0) d_wr = 1'b0;
      if (!d_wr) d_dst = '0;
   end

   assign taken = (opcode == OPC_J) || (opcode == OPC_JAL) ||
                  (opcode == OPC_BEQ && a_val == b_val) || (opcode == OPC_BNE && a_val != b_val);

   assign bus.j_ce   = fire && taken;
   assign bus.j_addr = !(fire && taken) ? '0 :
                       (opcode == OPC_J || opcode == OPC_JAL) ?
                          {bus.if_pc[DATA_W-1:28], bus.if_inst[25:0], 2'b00} :
                          bus.if_pc + DATA_W'(4) + {sext_imm[DATA_W-3:0], 2'b00};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_valid_q <= 1'b0; ex_op_q <= '0; ex_a_q <= '0; ex_b_q <= '0; ex_store_q <= '0;
         ex_wr_q <= 1'b0; ex_waddr_q <= '0; ex_load_q <= 1'b0; ex_sten_q <= 1'b0;
      end else if (fire) begin
         ex_valid_q <= 1'b1; ex_op_q <= d_op; ex_a_q <= d_a; ex_b_q <= d_b; ex_store_q <= d_store;
         ex_wr_q <= d_wr; ex_waddr_q <= d_dst; ex_load_q <= d_load; ex_sten_q <= d_sten;
      end else if (bus.ex_ready_i) begin
         ex_valid_q <= 1'b0;
      end
   end

   assign bus.if_ready   = rdy;
   assign bus.rega_addr  = rs;
   assign bus.regb_addr  = rt;
   assign bus.ex_valid   = ex_valid_q;
   assign bus.ex_op      = ex_op_q;
   assign bus.ex_rega    = ex_a_q;
   assign bus.ex_regb    = ex_b_q;
   assign bus.ex_store   = ex_store_q;
   assign bus.ex_wr      = ex_wr_q;
   assign bus.ex_waddr   = ex_waddr_q;
   assign bus.ex_load    = ex_load_q;
   assign bus.ex_storeen = ex_sten_q;
endmodule

// File: tb/tb_idu_pipe.sv
// Directed bench for idu_pipe: decode vector table plus reset, hold, load-use, RAW and branch sequences.
module tb_idu_pipe;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   fails  = 0;

   idu_pipe_if #(.DATA_W(32), .RADDR_W(5), .OP_W(5)) bus ();
   idu_pipe #(.DATA_W(32), .RADDR_W(5), .OP_W(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

   always #5 clk = ~clk;

   // RegFile stand-in: rN reads as N*0x101, r0 reads as 0.
   function automatic logic [31:0] rf(input logic [4:0] a);
      return {19'd0, a, 8'd0} | {27'd0, a};
   endfunction
   assign bus.rega_data_i = rf(bus.rega_addr);
   assign bus.regb_data_i = rf(bus.regb_addr);

   function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, sh, input logic [5:0] fn);
      return {6'd0, rs, rt, rd, sh, fn};
   endfunction
   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction
   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] t);
      return {op, t};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] inst, input logic rdy);
      @(negedge clk);
      bus.if_valid = v; bus.if_pc = pc; bus.if_inst = inst; bus.ex_ready_i = rdy;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drv(1'b0, 32'h0, 32'h0, 1'b1);
      tick();
   endtask

   typedef struct {
      string       name;
      logic [31:0] pc, inst;
      logic        jce;
      logic [31:0] jaddr;
      logic [4:0]  op;
      logic [31:0] a, b, st;
      logic        wr;
      logic [4:0]  wa;
      logic        ld, sten;
   } vec_t;
   vec_t vt[17];

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.if_valid = 1'b1; bus.if_pc = 32'h3000_0010; bus.if_inst = enc_j(6'h03, 26'h40);
      bus.ex_ready_i = 1'b1; bus.ex_result = '0; bus.mem_wr = 1'b0; bus.mem_waddr = '0; bus.mem_result = '0;

      vt[0]  = '{"add",   32'h0, enc_r(1,3,2,0,6'h20), 1'b0, 32'h0, 5'd0, 32'h101, 32'h303, 32'h0, 1'b1, 5'd2, 1'b0, 1'b0};
      vt[1]  = '{"sub",   32'h0, enc_r(5,6,4,0,6'h22), 1'b0, 32'h0, 5'd1, 32'h505, 32'h606, 32'h0, 1'b1, 5'd4, 1'b0, 1'b0};
      vt[2]  = '{"slt",   32'h0, enc_r(1,2,7,0,6'h2A), 1'b0, 32'h0, 5'd8, 32'h101, 32'h202, 32'h0, 1'b1, 5'd7, 1'b0, 1'b0};
      vt[3]  = '{"sra",   32'h0, enc_r(0,2,3,4,6'h03), 1'b0, 32'h0, 5'd7, 32'h4,   32'h202, 32'h0, 1'b1, 5'd3, 1'b0, 1'b0};
      vt[4]  = '{"badfn", 32'h0, enc_r(1,2,5,0,6'h21), 1'b0, 32'h0, 5'd0, 32'h101, 32'h202, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0};
      vt[5]  = '{"add_r0",32'h0, enc_r(1,2,0,0,6'h20), 1'b0, 32'h0, 5'd0, 32'h101, 32'h202, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0};
      vt[6]  = '{"addi",  32'h0, enc_i(6'h08,2,1,16'hFFFC), 1'b0, 32'h0, 5'd0, 32'h202, 32'hFFFF_FFFC, 32'h0, 1'b1, 5'd1, 1'b0, 1'b0};
      vt[7]  = '{"ori",   32'h0, enc_i(6'h0D,1,3,16'h8001), 1'b0, 32'h0, 5'd3, 32'h101, 32'h0000_8001, 32'h0, 1'b1, 5'd3, 1'b0, 1'b0};
      vt[8]  = '{"lui",   32'h0, enc_i(6'h0F,0,6,16'h1234), 1'b0, 32'h0, 5'd9, 32'h0, 32'h1234_0000, 32'h0, 1'b1, 5'd6, 1'b0, 1'b0};
      vt[9]  = '{"lw",    32'h0, enc_i(6'h23,2,3,16'h0008), 1'b0, 32'h0, 5'd0, 32'h202, 32'h8, 32'h0, 1'b1, 5'd3, 1'b1, 1'b0};
      vt[10] = '{"sw",    32'h0, enc_i(6'h2B,5,4,16'hFFF8), 1'b0, 32'h0, 5'd0, 32'h505, 32'hFFFF_FFF8, 32'h404, 1'b0, 5'd0, 1'b0, 1'b1};
      vt[11] = '{"jal",   32'h3000_0010, enc_j(6'h03,26'h40), 1'b1, 32'h3000_0100, 5'd0, 32'h3000_0010, 32'h4, 32'h0, 1'b1, 5'd31, 1'b0, 1'b0};
      vt[12] = '{"j",     32'h1000_0000, enc_j(6'h02,26'h3FF_FFFF), 1'b1, 32'h1FFF_FFFC, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0};
      vt[13] = '{"beq_t", 32'h200, enc_i(6'h04,1,1,16'h0003), 1'b1, 32'h210, 5'd0, 32'h101, 32'h101, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0};
      vt[14] = '{"bne_wr",32'h0,   enc_i(6'h05,1,2,16'hFFFE), 1'b1, 32'hFFFF_FFFC, 5'd0, 32'h101, 32'h202, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0};
      vt[15] = '{"beq_nt",32'h40,  enc_i(6'h04,1,2,16'h0005), 1'b0, 32'h0, 5'd0, 32'h101, 32'h202, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0};
      vt[16] = '{"nop",   32'h0, enc_i(6'h3F,0,7,16'h1234), 1'b0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0};

      // Reset with a jal presented: nothing fires, nothing redirects.
      #1 rst = 1'b0;
      #1;
      chk("rst_ex_valid", 32'(bus.ex_valid), 32'h0);
      chk("rst_ex_rega", bus.ex_rega, 32'h0);
      chk("rst_ex_wr", 32'(bus.ex_wr), 32'h0);
      chk("rst_j_ce", 32'(bus.j_ce), 32'h0);
      tick();
      chk("rst_hold_valid", 32'(bus.ex_valid), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rel_j_ce", 32'(bus.j_ce), 32'h1);
      chk("rel_j_addr", bus.j_addr, 32'h3000_0100);
      tick();
      chk("rel_ex_valid", 32'(bus.ex_valid), 32'h1);
      chk("rel_ex_waddr", 32'(bus.ex_waddr), 32'd31);

      for (int i = 0; i < 17; i++) begin
         idle();
         drv(1'b1, vt[i].pc, vt[i].inst, 1'b1);
         chk({vt[i].name, "_if_ready"}, 32'(bus.if_ready), 32'h1);
         chk({vt[i].name, "_j_ce"}, 32'(bus.j_ce), 32'(vt[i].jce));
         chk({vt[i].name, "_j_addr"}, bus.j_addr, vt[i].jaddr);
         tick();
         chk({vt[i].name, "_valid"}, 32'(bus.ex_valid), 32'h1);
         chk({vt[i].name, "_op"}, 32'(bus.ex_op), 32'(vt[i].op));
         chk({vt[i].name, "_rega"}, bus.ex_rega, vt[i].a);
         chk({vt[i].name, "_regb"}, bus.ex_regb, vt[i].b);
         chk({vt[i].name, "_store"}, bus.ex_store, vt[i].st);
         chk({vt[i].name, "_wr"}, 32'(bus.ex_wr), 32'(vt[i].wr));
         chk({vt[i].name, "_waddr"}, 32'(bus.ex_waddr), 32'(vt[i].wa));
         chk({vt[i].name, "_load"}, 32'(bus.ex_load), 32'(vt[i].ld));
         chk({vt[i].name, "_storeen"}, 32'(bus.ex_storeen), 32'(vt[i].sten));
      end

      // EX backpressure for 3 cycles: ID/EX holds, then the waiting addi is taken exactly once.
      idle();
      drv(1'b1, 32'h0, enc_i(6'h0F,0,6,16'h1234), 1'b1);
      tick();
      for (int k = 0; k < 3; k++) begin
         drv(1'b1, 32'h4, enc_i(6'h08,0,1,16'h0005), 1'b0);
         chk("hold_if_ready", 32'(bus.if_ready), 32'h0);
         tick();
         chk("hold_valid", 32'(bus.ex_valid), 32'h1);
         chk("hold_regb", bus.ex_regb, 32'h1234_0000);
         chk("hold_waddr", 32'(bus.ex_waddr), 32'd6);
      end
      drv(1'b1, 32'h4, enc_i(6'h08,0,1,16'h0005), 1'b1);
      chk("rel_if_ready", 32'(bus.if_ready), 32'h1);
      tick();
      chk("rel_regb", bus.ex_regb, 32'h5);
      chk("rel_waddr", 32'(bus.ex_waddr), 32'd1);
      drv(1'b0, 32'h8, 32'h0, 1'b1);
      tick();
      chk("rel_once", 32'(bus.ex_valid), 32'h0);

      // Load-use: lw r3 then or r4,r3,r0.
      idle();
      drv(1'b1, 32'h0, enc_i(6'h23,0,3,16'h0000), 1'b1);
      tick();
      chk("lu_load", 32'(bus.ex_load), 32'h1);
      drv(1'b1, 32'h4, enc_r(3,0,4,0,6'h25), 1'b1);
      chk("lu_stall", 32'(bus.if_ready), 32'h0);
      tick();
      chk("lu_bubble", 32'(bus.ex_valid), 32'h0);
      bus.mem_wr = 1'b1; bus.mem_waddr = 5'd3; bus.mem_result = 32'hDEAD_BEEF;
      drv(1'b1, 32'h4, enc_r(3,0,4,0,6'h25), 1'b1);
`ifdef IDU_FWD_EN
      chk("lu_issue_rdy", 32'(bus.if_ready), 32'h1);
      tick();
      chk("lu_issue_valid", 32'(bus.ex_valid), 32'h1);
      chk("lu_issue_rega", bus.ex_rega, 32'hDEAD_BEEF);
      chk("lu_issue_op", 32'(bus.ex_op), 32'd3);
`else
      chk("lu_mem_stall", 32'(bus.if_ready), 32'h0);
      tick();
      chk("lu_mem_bubble", 32'(bus.ex_valid), 32'h0);
      bus.mem_wr = 1'b0;
      drv(1'b1, 32'h4, enc_r(3,0,4,0,6'h25), 1'b1);
      chk("lu_issue_rdy", 32'(bus.if_ready), 32'h1);
      tick();
      chk("lu_issue_valid", 32'(bus.ex_valid), 32'h1);
      chk("lu_issue_rega", bus.ex_rega, 32'h303);
`endif
      bus.mem_wr = 1'b0;

      // RAW on EX result: addi r1,r0,-1 then add r2,r1,r1.
      idle();
      drv(1'b1, 32'h0, enc_i(6'h08,0,1,16'hFFFF), 1'b1);
      tick();
      bus.ex_result = 32'hFFFF_FFFF;
      drv(1'b1, 32'h4, enc_r(1,1,2,0,6'h20), 1'b1);
`ifdef IDU_FWD_EN
      chk("raw_rdy", 32'(bus.if_ready), 32'h1);
      tick();
      chk("raw_rega", bus.ex_rega, 32'hFFFF_FFFF);
      chk("raw_regb", bus.ex_regb, 32'hFFFF_FFFF);
      chk("raw_waddr", 32'(bus.ex_waddr), 32'd2);
`else
      chk("raw_ex_stall", 32'(bus.if_ready), 32'h0);
      tick();
      chk("raw_bubble", 32'(bus.ex_valid), 32'h0);
      bus.mem_wr = 1'b1; bus.mem_waddr = 5'd1; bus.mem_result = 32'hFFFF_FFFF;
      drv(1'b1, 32'h4, enc_r(1,1,2,0,6'h20), 1'b1);
      chk("raw_mem_stall", 32'(bus.if_ready), 32'h0);
      tick();
      bus.mem_wr = 1'b0;
      drv(1'b1, 32'h4, enc_r(1,1,2,0,6'h20), 1'b1);
      chk("raw_rdy", 32'(bus.if_ready), 32'h1);
      tick();
      chk("raw_rega", bus.ex_rega, 32'h101);
      chk("raw_regb", bus.ex_regb, 32'h101);
`endif
      bus.ex_result = '0;

      // Branch at pc 0x100, imm -1 -> target 0x100.
      idle();
      drv(1'b1, 32'h0, enc_i(6'h08,0,1,16'h0005), 1'b1);
      tick();
`ifdef IDU_FWD_EN
      bus.ex_result = 32'h202;
      drv(1'b1, 32'h100, enc_i(6'h04,1,2,16'hFFFF), 1'b1);
      chk("beq_fwd_jce", 32'(bus.j_ce), 32'h1);
      chk("beq_fwd_addr", bus.j_addr, 32'h100);
      tick();
      idle();
      drv(1'b1, 32'h0, enc_i(6'h08,0,1,16'h0005), 1'b1);
      tick();
      drv(1'b1, 32'h100, enc_i(6'h05,1,2,16'hFFFF), 1'b1);
      chk("bne_fwd_jce", 32'(bus.j_ce), 32'h0);
      chk("bne_fwd_addr", bus.j_addr, 32'h0);
      tick();
`else
      drv(1'b1, 32'h100, enc_i(6'h05,1,2,16'hFFFF), 1'b1);
      chk("bne_stall_jce", 32'(bus.j_ce), 32'h0);
      chk("bne_stall_rdy", 32'(bus.if_ready), 32'h0);
      tick();
      bus.mem_wr = 1'b1; bus.mem_waddr = 5'd1;
      drv(1'b1, 32'h100, enc_i(6'h05,1,2,16'hFFFF), 1'b1);
      chk("bne_mem_jce", 32'(bus.j_ce), 32'h0);
      tick();
      bus.mem_wr = 1'b0;
      drv(1'b1, 32'h100, enc_i(6'h05,1,2,16'hFFFF), 1'b1);
      chk("bne_fire_jce", 32'(bus.j_ce), 32'h1);
      chk("bne_fire_addr", bus.j_addr, 32'h100);
      tick();
`endif
      bus.ex_result = '0;
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
